// File: rtl/lane_deskew_controller.sv
// Multi-lane deskew sequencer: resets the latency monitor, collects per-lane
// latencies, checks the skew budget, programs buffer delays and releases on LMFC.
module lane_deskew_controller #(
  parameter int L             = 4,
  parameter int MAX_SKEW      = 8,
  parameter int TIMEOUT_BEATS = 4095,
  parameter int MAX_RETRIES   = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic [L*14-1:0] lane_latency_i,
  input  logic [L-1:0]    lane_latency_ready_i,
  input  logic            lmfc_edge_i,
  output logic            monitor_rst_no,
  output logic [L*11-1:0] lane_delay_o,
  output logic            lane_release_o,
  output logic            aligned_o,
  output logic            skew_err_o,
  output logic            timeout_o,
  output logic [1:0]      retry_cnt_o,
  output logic [2:0]      state_o
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT    = 3'd2,
    S_SCAN    = 3'd3,
    S_CHECK   = 3'd4,
    S_ARM     = 3'd5,
    S_ALIGNED = 3'd6,
    S_FAIL    = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic [15:0]   tmo_cnt_q;
  logic [10:0]   max_q, min_q;
  logic [IW-1:0] idx_q;
  logic          clr_second_q;
  logic [10:0]   delay_q [L];
  logic          mon_rst_n_q, release_q, skew_err_q, timeout_q;
  logic [1:0]    retry_q;

  logic [10:0]   lat_b [L];
  logic [L*3-1:0] unused_frame_bits;
  logic [10:0]   scan_b;
  logic [10:0]   skew;
  logic          all_ready;

  // Only the beat count takes part in deskew; frame-align bits are ignored.
  for (genvar g = 0; g < L; g++) begin : g_lane
    assign lat_b[g]                   = lane_latency_i[g*14+3 +: 11];
    assign unused_frame_bits[g*3 +: 3] = lane_latency_i[g*14 +: 3];
    assign lane_delay_o[g*11 +: 11]   = delay_q[g];
  end

  logic unused_frame;
  assign unused_frame = ^unused_frame_bits;

  assign scan_b    = lat_b[idx_q];
  assign skew      = max_q - min_q;
  assign all_ready = &lane_latency_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (enable_i) state_d = S_CLEAR;
      S_CLEAR:   if (clr_second_q) state_d = S_WAIT;
      S_WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (all_ready)                                  state_d = S_SCAN;
        else if (tmo_cnt_q == 16'(TIMEOUT_BEATS - 1))   state_d = S_FAIL;
      end
      S_SCAN: begin
        if (!all_ready)                 state_d = S_CLEAR;
        else if (idx_q == IW'(L - 1))   state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!all_ready)                 state_d = S_CLEAR;
        else if (skew > 11'(MAX_SKEW))  state_d = S_FAIL;
        else                            state_d = S_ARM;
      end
      S_ARM: begin
        if (!all_ready)       state_d = S_CLEAR;
        else if (lmfc_edge_i) state_d = S_ALIGNED;
      end
      S_ALIGNED: if (!all_ready) state_d = S_CLEAR;
      S_FAIL:    if (retry_q < 2'(MAX_RETRIES)) state_d = S_CLEAR;
      default:   state_d = S_IDLE;
    endcase
    if (!enable_i) state_d = S_IDLE;
  end

  // Outputs are registered from the next state so that reset or disable
  // can never produce a combinational release glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q    <= '0;
      max_q        <= '0;
      min_q        <= 11'h7FF;
      idx_q        <= '0;
      clr_second_q <= 1'b0;
      mon_rst_n_q  <= 1'b0;
      release_q    <= 1'b0;
      skew_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      retry_q      <= '0;
      for (int i = 0; i < L; i++) delay_q[i] <= '0;
    end else if (!enable_i) begin
      tmo_cnt_q    <= '0;
      max_q        <= '0;
      min_q        <= 11'h7FF;
      idx_q        <= '0;
      clr_second_q <= 1'b0;
      mon_rst_n_q  <= 1'b0;
      release_q    <= 1'b0;
      skew_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      retry_q      <= '0;
      for (int i = 0; i < L; i++) delay_q[i] <= '0;
    end else begin
      clr_second_q <= (state_q == S_CLEAR) && !clr_second_q;
      mon_rst_n_q  <= state_d inside {S_WAIT, S_SCAN, S_CHECK, S_ARM, S_ALIGNED};
      release_q    <= (state_d == S_ALIGNED);

      if (state_d == S_CLEAR && state_q != S_CLEAR) begin
        skew_err_q <= 1'b0;
        timeout_q  <= 1'b0;
      end
      // Ready loss before alignment restarts without consuming a retry.
      if ((state_q == S_FAIL || state_q == S_ALIGNED) && state_d == S_CLEAR &&
          retry_q != 2'b11)
        retry_q <= retry_q + 2'd1;

      unique case (state_q)
        S_CLEAR: begin
          tmo_cnt_q <= '0;
          max_q     <= '0;
          min_q     <= 11'h7FF;
          idx_q     <= '0;
        end
        S_WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
          if (state_d == S_FAIL) timeout_q <= 1'b1;
        end
        S_SCAN: begin
          if (scan_b > max_q) max_q <= scan_b;
          if (scan_b < min_q) min_q <= scan_b;
          idx_q <= idx_q + IW'(1);
        end
        S_CHECK: begin
          if (state_d == S_FAIL) skew_err_q <= 1'b1;
          else if (state_d == S_ARM)
            for (int i = 0; i < L; i++) delay_q[i] <= max_q - lat_b[i];
        end
        default: ;
      endcase
    end
  end

  assign monitor_rst_no = mon_rst_n_q;
  assign lane_release_o = release_q;
  assign aligned_o      = release_q;
  assign skew_err_o     = skew_err_q;
  assign timeout_o      = timeout_q;
  assign retry_cnt_o    = retry_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_lane_deskew_controller.sv
// Directed bench for lane_deskew_controller: alignment, skew failure with retries,
// WAIT timeout, ready/timeout race, ready loss, disable and async reset.
module tb_lane_deskew_controller;

  localparam int L = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            enable_i;
  logic [L*14-1:0] lane_latency_i;
  logic [L-1:0]    lane_latency_ready_i;
  logic            lmfc_edge_i;
  logic            monitor_rst_no;
  logic [L*11-1:0] lane_delay_o;
  logic            lane_release_o;
  logic            aligned_o;
  logic            skew_err_o;
  logic            timeout_o;
  logic [1:0]      retry_cnt_o;
  logic [2:0]      state_o;

  int n_cmp = 0;
  int n_err = 0;
  int rel_rise = 0;

  lane_deskew_controller #(
    .L(L), .MAX_SKEW(8), .TIMEOUT_BEATS(20), .MAX_RETRIES(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .lane_latency_i(lane_latency_i), .lane_latency_ready_i(lane_latency_ready_i),
    .lmfc_edge_i(lmfc_edge_i), .monitor_rst_no(monitor_rst_no),
    .lane_delay_o(lane_delay_o), .lane_release_o(lane_release_o),
    .aligned_o(aligned_o), .skew_err_o(skew_err_o), .timeout_o(timeout_o),
    .retry_cnt_o(retry_cnt_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge lane_release_o) rel_rise++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [L*14-1:0] pack_lat(input int b0, b1, b2, b3);
    // Non-zero frame-align bits must not influence the beat comparison.
    return {11'(b3), 3'd5, 11'(b2), 3'd2, 11'(b1), 3'd7, 11'(b0), 3'd1};
  endfunction

  task automatic wait_state(input logic [2:0] s, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (state_o === s) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; enable_i = 1'b0; lmfc_edge_i = 1'b0;
    lane_latency_ready_i = '0; lane_latency_i = '0;
    repeat (2) tick();
    n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if ({monitor_rst_no, lane_release_o, aligned_o, skew_err_o, timeout_o, retry_cnt_o} !== 7'd0) begin
      n_err++; $display("FAIL reset_flags: got %b want 0", {monitor_rst_no, lane_release_o, aligned_o, skew_err_o, timeout_o, retry_cnt_o}); end
    n_cmp++; if (lane_delay_o !== '0) begin n_err++; $display("FAIL reset_delay: got %h want 0", lane_delay_o); end
    rst_ni = 1'b1;
    tick();
    n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", state_o); end
  endtask

  task automatic test_align();
    logic [L*11-1:0] exp_delay;
    exp_delay = {11'd0, 11'd2, 11'd1, 11'd3};
    lane_latency_i = pack_lat(10, 12, 11, 13);
    lane_latency_ready_i = 4'b0000;
    enable_i = 1'b1;
    tick();
    n_cmp++; if (state_o !== 3'd1 || monitor_rst_no !== 1'b0) begin n_err++; $display("FAIL clear_c1: state %0d mon %b want 1/0", state_o, monitor_rst_no); end
    tick();
    n_cmp++; if (state_o !== 3'd1 || monitor_rst_no !== 1'b0) begin n_err++; $display("FAIL clear_c2: state %0d mon %b want 1/0", state_o, monitor_rst_no); end
    tick();
    n_cmp++; if (state_o !== 3'd2 || monitor_rst_no !== 1'b1) begin n_err++; $display("FAIL wait_entry: state %0d mon %b want 2/1", state_o, monitor_rst_no); end
    tick();
    n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL wait_hold: got %0d want 2", state_o); end
    lane_latency_ready_i = 4'b1111;
    tick();
    n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL scan_entry: got %0d want 3", state_o); end
    repeat (3) tick();
    n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL scan_len: got %0d want 3", state_o); end
    tick();
    n_cmp++; if (state_o !== 3'd4) begin n_err++; $display("FAIL check_entry: got %0d want 4", state_o); end
    lmfc_edge_i = 1'b1;  // coincides with ARM entry, must be ignored
    tick();
    lmfc_edge_i = 1'b0;
    n_cmp++; if (state_o !== 3'd5) begin n_err++; $display("FAIL arm_entry: got %0d want 5", state_o); end
    n_cmp++; if (lane_delay_o !== exp_delay) begin n_err++; $display("FAIL delays: got %h want %h", lane_delay_o, exp_delay); end
    repeat (4) tick();
    n_cmp++; if (state_o !== 3'd5 || lane_release_o !== 1'b0 || aligned_o !== 1'b0) begin
      n_err++; $display("FAIL arm_hold: state %0d rel %b al %b want 5/0/0", state_o, lane_release_o, aligned_o); end
    lmfc_edge_i = 1'b1;
    tick();
    lmfc_edge_i = 1'b0;
    n_cmp++; if (state_o !== 3'd6 || lane_release_o !== 1'b1 || aligned_o !== 1'b1) begin
      n_err++; $display("FAIL aligned: state %0d rel %b al %b want 6/1/1", state_o, lane_release_o, aligned_o); end
    lane_latency_i = pack_lat(40, 2, 7, 9);
    tick();
    n_cmp++; if (lane_delay_o !== exp_delay || state_o !== 3'd6) begin
      n_err++; $display("FAIL delay_frozen: got %h state %0d want %h state 6", lane_delay_o, state_o, exp_delay); end
  endtask

  task automatic test_ready_drop();
    lane_latency_ready_i = 4'b1101;
    tick();
    n_cmp++; if (state_o !== 3'd1 || aligned_o !== 1'b0 || lane_release_o !== 1'b0) begin
      n_err++; $display("FAIL drop_state: state %0d al %b rel %b want 1/0/0", state_o, aligned_o, lane_release_o); end
    n_cmp++; if (retry_cnt_o !== 2'd1) begin n_err++; $display("FAIL drop_retry: got %0d want 1", retry_cnt_o); end
    enable_i = 1'b0;
    tick();
    n_cmp++; if (state_o !== 3'd0 || retry_cnt_o !== 2'd0 || lane_delay_o !== '0) begin
      n_err++; $display("FAIL disable_clear: state %0d retry %0d delay %h want 0", state_o, retry_cnt_o, lane_delay_o); end
  endtask

  task automatic test_skew_retry();
    bit found;
    lane_latency_i = pack_lat(10, 30, 10, 10);
    lane_latency_ready_i = 4'b1111;
    enable_i = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      wait_state(3'd7, 30, found);
      n_cmp++; if (!found) begin n_err++; $display("FAIL skew_fail_reach%0d: state %0d want 7", r, state_o); end
      n_cmp++; if (skew_err_o !== 1'b1 || retry_cnt_o !== 2'(r - 1)) begin
        n_err++; $display("FAIL skew_flag%0d: err %b retry %0d want 1/%0d", r, skew_err_o, retry_cnt_o, r - 1); end
      tick();
      n_cmp++; if (state_o !== 3'd1 || retry_cnt_o !== 2'(r) || skew_err_o !== 1'b0) begin
        n_err++; $display("FAIL skew_retry%0d: state %0d retry %0d err %b want 1/%0d/0", r, state_o, retry_cnt_o, skew_err_o, r); end
    end
    wait_state(3'd7, 30, found);
    n_cmp++; if (!found) begin n_err++; $display("FAIL skew_final_reach: state %0d want 7", state_o); end
    repeat (5) tick();
    n_cmp++; if (state_o !== 3'd7 || retry_cnt_o !== 2'd3 || skew_err_o !== 1'b1 || monitor_rst_no !== 1'b0) begin
      n_err++; $display("FAIL skew_stuck: state %0d retry %0d err %b mon %b want 7/3/1/0", state_o, retry_cnt_o, skew_err_o, monitor_rst_no); end
    enable_i = 1'b0;
    tick();
    n_cmp++; if (state_o !== 3'd0 || skew_err_o !== 1'b0 || retry_cnt_o !== 2'd0) begin
      n_err++; $display("FAIL skew_idle: state %0d err %b retry %0d want 0/0/0", state_o, skew_err_o, retry_cnt_o); end
  endtask

  task automatic test_timeout();
    lane_latency_i = pack_lat(10, 12, 11, 13);
    lane_latency_ready_i = 4'b1011;
    enable_i = 1'b1;
    repeat (3) tick();            // CLEAR, CLEAR, WAIT cycle 1
    repeat (19) tick();           // now in WAIT cycle 20
    n_cmp++; if (state_o !== 3'd2 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL tmo_wait20: state %0d tmo %b want 2/0", state_o, timeout_o); end
    tick();
    n_cmp++; if (state_o !== 3'd7 || timeout_o !== 1'b1) begin
      n_err++; $display("FAIL tmo_fail: state %0d tmo %b want 7/1", state_o, timeout_o); end
    tick();
    n_cmp++; if (state_o !== 3'd1 || retry_cnt_o !== 2'd1 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL tmo_retry: state %0d retry %0d tmo %b want 1/1/0", state_o, retry_cnt_o, timeout_o); end
    enable_i = 1'b0;
    tick();
  endtask

  task automatic test_ready_vs_timeout();
    bit found;
    lane_latency_ready_i = 4'b0000;
    enable_i = 1'b1;
    repeat (3) tick();
    repeat (19) tick();
    lane_latency_ready_i = 4'b1111;  // arrives on the cycle the counter is at 19
    tick();
    n_cmp++; if (state_o !== 3'd3 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL race_scan: state %0d tmo %b want 3/0", state_o, timeout_o); end
    wait_state(3'd5, 10, found);
    n_cmp++; if (!found) begin n_err++; $display("FAIL race_arm: state %0d want 5", state_o); end
  endtask

  task automatic test_disable_and_reset();
    bit found;
    int rel_before;
    rel_before = rel_rise;
    enable_i = 1'b0;
    tick();
    n_cmp++; if (state_o !== 3'd0 || monitor_rst_no !== 1'b0 || lane_delay_o !== '0 ||
                 lane_release_o !== 1'b0 || aligned_o !== 1'b0) begin
      n_err++; $display("FAIL arm_disable: state %0d mon %b delay %h rel %b want 0", state_o, monitor_rst_no, lane_delay_o, lane_release_o); end
    enable_i = 1'b1;
    wait_state(3'd3, 10, found);
    n_cmp++; if (!found) begin n_err++; $display("FAIL rst_scan_reach: state %0d want 3", state_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (state_o !== 3'd0 || monitor_rst_no !== 1'b0 || lane_delay_o !== '0) begin
      n_err++; $display("FAIL async_rst: state %0d mon %b delay %h want 0", state_o, monitor_rst_no, lane_delay_o); end
    tick();
    rst_ni = 1'b1;
    #1;
    n_cmp++; if (state_o !== 3'd0 || lane_release_o !== 1'b0) begin
      n_err++; $display("FAIL rst_release: state %0d rel %b want 0/0", state_o, lane_release_o); end
    n_cmp++; if (rel_rise !== rel_before) begin
      n_err++; $display("FAIL release_glitch: got %0d rises want %0d", rel_rise, rel_before); end
    tick();
    n_cmp++; if (state_o !== 3'd1) begin n_err++; $display("FAIL post_rst_clear: got %0d want 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_align();
    test_ready_drop();
    test_skew_retry();
    test_timeout();
    test_ready_vs_timeout();
    test_disable_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lane_deskew_controller.md
Name: lane_deskew_controller

Overview:
- Sequences the per-lane latency monitor and turns its measurements into a multi-lane deskew plan for the JESD204B RX path.
- Holds the monitor in reset, releases it, and waits for every lane to report a captured latency.
- Serially finds the earliest and latest lane, checks the skew budget, and drives per-lane buffer delays.
- Issues a single synchronous release on the next LMFC edge.

Parameters:
- L, 4, number of JESD lanes.
- MAX_SKEW, 8, maximum allowed (latest − earliest) beat difference.
- TIMEOUT_BEATS, 4095, beats allowed in WAIT before declaring timeout; range 1..65535.
- MAX_RETRIES, 3, automatic restarts after a failure before the controller stays in FAIL.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  level; 1 = run alignment, 0 = return to IDLE.
- lane_latency_i  in  L*14  per lane {11-bit beat count [13:3], 3-bit frame align [2:0]}.
- lane_latency_ready_i  in  L  per-lane capture-done flags from the monitor.
- lmfc_edge_i  in  1  single-cycle LMFC boundary strobe.
- monitor_rst_no  out  1  synchronous active-low reset to the latency monitor.
- lane_delay_o  out  L*11  per-lane buffer delay in beats.
- lane_release_o  out  1  level; elastic-buffer read release.
- aligned_o  out  1  deskew complete.
- skew_err_o  out  1  sticky skew-budget violation.
- timeout_o  out  1  sticky WAIT timeout.
- retry_cnt_o  out  2  restarts performed since leaving IDLE, saturating.
- state_o  out  3  FSM state encoding for debug.

Behaviour:
- Reset values:
  - state IDLE; monitor_rst_no = 0.
  - All other outputs 0, including lane_delay_o, retry_cnt_o and state_o.
  - Internal max = 0, min = 11'h7FF, idx = 0, timeout counter = 0.
- State encodings: IDLE=0, CLEAR=1, WAIT=2, SCAN=3, CHECK=4, ARM=5, ALIGNED=6, FAIL=7.
- enable_i = 0 in any state: next cycle IDLE, with every output at its reset value. This overrides all other transitions.
- IDLE: monitor_rst_no = 0. If enable_i = 1, go to CLEAR.
- CLEAR: monitor_rst_no = 0 for exactly 2 cycles. Timeout counter, max, min and idx are cleared. Then go to WAIT.
- WAIT:
  - monitor_rst_no = 1; the counter increments once per cycle.
  - If all lane_latency_ready_i bits = 1, go to SCAN. This is checked before the timeout.
  - Otherwise, if counter == TIMEOUT_BEATS − 1, set timeout_o and go to FAIL.
- SCAN:
  - One lane per cycle, lanes 0..L−1, so SCAN lasts exactly L cycles.
  - Take field b = lane_latency_i[idx*14+3 +: 11]; update max = max(max, b) and min = min(min, b).
  - All comparisons are unsigned. After idx = L−1, go to CHECK.
- CHECK (1 cycle):
  - If max − min > MAX_SKEW (11-bit unsigned; max ≥ min is guaranteed), set skew_err_o and go to FAIL.
  - Otherwise register lane_delay_o[i] = max − b_i for every lane and go to ARM.
- ARM: wait for lmfc_edge_i, which is sampled only while in ARM. On the edge, go to ALIGNED; lane_release_o and aligned_o rise together on the following clock.
- ALIGNED:
  - lane_release_o = 1, aligned_o = 1, lane_delay_o frozen.
  - Any lane_latency_ready_i bit falling: go to CLEAR. aligned_o and lane_release_o drop the next cycle, and retry_cnt_o increments.
- FAIL:
  - Error flags stay set until IDLE.
  - If retry_cnt_o < MAX_RETRIES: increment retry_cnt_o, go to CLEAR next cycle, and clear the error flags on CLEAR entry.
  - Otherwise stay in FAIL, flags held, monitor_rst_no = 0.
- Simultaneous events:
  - Ready-complete and timeout in the same WAIT cycle: ready wins.
  - lmfc_edge_i in the same cycle as entering ARM is ignored.
- Lane_latency_ready_i dropping during SCAN, CHECK or ARM: go to CLEAR without a retry increment.
- Asynchronous reset mid-operation: immediate return to reset values, no release glitch.

Test Plan:
- L=4, ready at beats {10,12,11,13}, edge 5 cycles after ARM → monitor_rst_no low 2 cycles; lane_delay_o = {3,1,2,0} for lanes 0..3; release and aligned_o rise exactly 1 cycle after the edge.
- Latencies {10,30,10,10} with MAX_SKEW=8 → skew_err_o=1; FAIL, then CLEAR with retry_cnt_o=1; after 3 repeated failures retry_cnt_o=3, stuck in FAIL.
- TIMEOUT_BEATS=20, lane 2 never ready → timeout_o=1 on WAIT cycle 20; FAIL, then retry.
- All lanes ready on the same cycle the timeout counter hits 19 → SCAN entered, timeout_o stays 0.
- ALIGNED, lane 1 ready drops → aligned_o and lane_release_o drop next cycle; state CLEAR; retry_cnt_o increments.
- enable_i deasserted in ARM, then rst_ni pulsed mid-SCAN → IDLE with all outputs at reset values, monitor_rst_no=0, no lane_release_o pulse.
